// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if
//   Bundles the byte-strobe input, consumer handshake and held-frame outputs
//   of uart_frame_parser.
//   slave  : the parser side (consumes rx bytes / ack, drives frame outputs)
//   master : the environment side (UART receiver + road-control consumer)
//   Signals:
//     i_rx_done, i_rx_data     byte strobe and data from the UART receiver
//     i_ack                    consumer acknowledge, releases a held frame
//     i_rd_idx                 payload read index
//     o_frame_valid            level, high while a validated frame is held
//     o_cmd, o_len             CMD / LEN of the held frame
//     o_payload_byte           payload[i_rd_idx]
//     o_frame_err, o_err_code  rejection pulse and its reason (1 len, 2 chk, 3 timeout)
//     o_overrun                pulse when a byte is dropped while holding
interface uart_frame_parser_if #(
  parameter int MAX_LEN = 8
);
  // Read index width; kept at least 1 bit so MAX_LEN=1 still has a port.
  localparam int RDW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic           i_rx_done;
  logic [7:0]     i_rx_data;
  logic           i_ack;
  logic [RDW-1:0] i_rd_idx;
  logic           o_frame_valid;
  logic [7:0]     o_cmd;
  logic [7:0]     o_len;
  logic [7:0]     o_payload_byte;
  logic           o_frame_err;
  logic [1:0]     o_err_code;
  logic           o_overrun;

  modport slave (
    input  i_rx_done, i_rx_data, i_ack, i_rd_idx,
    output o_frame_valid, o_cmd, o_len, o_payload_byte,
           o_frame_err, o_err_code, o_overrun
  );

  modport master (
    output i_rx_done, i_rx_data, i_ack, i_rd_idx,
    input  o_frame_valid, o_cmd, o_len, o_payload_byte,
           o_frame_err, o_err_code, o_overrun
  );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Assembles HEADER, CMD, LEN, PAYLOAD[LEN], CHK frames from one-cycle UART
//   byte strobes. Rejects LEN > MAX_LEN, XOR checksum mismatches and
//   inter-byte gaps of TIMEOUT_CYC cycles. A good frame is held (valid level)
//   until i_ack; bytes arriving meanwhile are dropped with an overrun pulse.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     bus    uart_frame_parser_if.slave (byte strobe in, frame/status out)
module uart_frame_parser #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  uart_frame_parser_if.slave bus
);
  localparam int RDW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IDXW = $clog2(MAX_LEN + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;

  logic [2:0]      state_q;
  logic [7:0]      chk_q;
  logic [IDXW-1:0] idx_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      cmd_sh, len_sh;
  logic [7:0]      cmd_q, len_q;
  logic            err_q, ovr_q;
  logic [1:0]      code_q;

  // Depth rounded to a power of two so every read index is in range.
  logic [7:0] pbuf [0:(1<<RDW)-1];

  logic       rx;
  logic [7:0] rx_byte;
  logic       in_frame;
  logic       tmo_hit;

  assign rx       = bus.i_rx_done;
  assign rx_byte  = bus.i_rx_data;
  assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // A byte in the terminal cycle wins over the timeout.
  assign tmo_hit  = in_frame && !rx && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      chk_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      cmd_sh  <= '0;
      len_sh  <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
      // Gap counter only runs mid-frame and restarts on every consumed byte.
      if (in_frame && !rx) tmo_q <= tmo_q + 1'b1;
      else                 tmo_q <= '0;

      if (tmo_hit) begin
        err_q   <= 1'b1;
        code_q  <= 2'd3;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (rx && rx_byte == HEADER) begin
            chk_q   <= '0;
            state_q <= S_CMD;
          end
          S_CMD: if (rx) begin
            cmd_sh  <= rx_byte;
            chk_q   <= rx_byte;
            state_q <= S_LEN;
          end
          S_LEN: if (rx) begin
            if (rx_byte > 8'(MAX_LEN)) begin
              err_q   <= 1'b1;
              code_q  <= 2'd1;
              state_q <= S_IDLE;
            end else begin
              len_sh  <= rx_byte;
              chk_q   <= chk_q ^ rx_byte;
              idx_q   <= '0;
              state_q <= (rx_byte == 8'd0) ? S_CHK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: if (rx) begin
            chk_q <= chk_q ^ rx_byte;
            idx_q <= idx_q + 1'b1;
            if (8'(idx_q) + 8'd1 == len_sh) state_q <= S_CHK;
          end
          S_CHK: if (rx) begin
            if (rx_byte == chk_q) begin
              cmd_q   <= cmd_sh;
              len_q   <= len_sh;
              state_q <= S_HOLD;
            end else begin
              err_q   <= 1'b1;
              code_q  <= 2'd2;
              state_q <= S_IDLE;
            end
          end
          S_HOLD: begin
            // Dropped outright, even in the ack cycle: never seen as a header.
            if (rx)        ovr_q   <= 1'b1;
            if (bus.i_ack) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_PAYLOAD && rx)
      pbuf[idx_q[RDW-1:0]] <= rx_byte;
  end

  assign bus.o_frame_valid  = (state_q == S_HOLD);
  assign bus.o_cmd          = cmd_q;
  assign bus.o_len          = len_q;
  assign bus.o_payload_byte = pbuf[bus.i_rd_idx];
  assign bus.o_frame_err    = err_q;
  assign bus.o_err_code     = code_q;
  assign bus.o_overrun      = ovr_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//   Table of hand-computed per-cycle vectors, hand sequences for timeout and
//   mid-frame reset, then randomized byte streams checked against a
//   byte-list reference model of the frame format.
module tb_uart_frame_parser;
  localparam int         MAX_LEN = 8;
  localparam int         TO      = 50;
  localparam logic [7:0] HDR     = 8'hAA;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus();

  uart_frame_parser #(.HEADER(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_model = 0;

  // ---------------- reference model ----------------
  bit         m_in, m_held, m_err, m_ovr;
  int         m_idle;
  logic [7:0] m_fb[$];
  logic [7:0] m_cmd, m_len;
  logic [1:0] m_code;
  logic [7:0] m_pl [0:7];

  function automatic void model_step(bit rst, bit rx, logic [7:0] d, bit ack);
    logic [7:0] x;
    m_err = 0;
    m_ovr = 0;
    if (rst) begin
      m_in = 0; m_held = 0; m_idle = 0; m_cmd = 0; m_len = 0; m_code = 0;
      return;
    end
    if (m_held) begin
      if (rx)  m_ovr  = 1;
      if (ack) m_held = 0;
    end else if (!m_in) begin
      if (rx && d == HDR) begin
        m_in = 1; m_fb.delete(); m_idle = 0;
      end
    end else if (rx) begin
      m_idle = 0;
      m_fb.push_back(d);
      if (m_fb.size() == 2 && int'(m_fb[1]) > MAX_LEN) begin
        m_err = 1; m_code = 1; m_in = 0;
      end else if (m_fb.size() >= 2 && m_fb.size() == int'(m_fb[1]) + 3) begin
        x = 8'h00;
        for (int i = 0; i < m_fb.size() - 1; i++) x = x ^ m_fb[i];
        if (x == m_fb[m_fb.size()-1]) begin
          m_held = 1; m_cmd = m_fb[0]; m_len = m_fb[1];
          for (int i = 0; i < int'(m_len); i++) m_pl[i] = m_fb[2+i];
        end else begin
          m_err = 1; m_code = 2;
        end
        m_in = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_err = 1; m_code = 3; m_in = 0;
      end
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input bit rx, input logic [7:0] d, input bit ack, input logic [2:0] idx);
    @(negedge clk);
    bus.i_rx_done = rx;
    bus.i_rx_data = d;
    bus.i_ack     = ack;
    bus.i_rd_idx  = idx;
    @(posedge clk);
    model_step(reset, rx, d, ack);
    #1;
    bus.i_rx_done = 1'b0;
    bus.i_ack     = 1'b0;
    if (cmp_model) begin
      check("r_valid", bus.o_frame_valid, m_held);
      check("r_err",   bus.o_frame_err,   m_err);
      check("r_ovr",   bus.o_overrun,     m_ovr);
      check("r_code",  bus.o_err_code,    m_code);
      if (m_held) begin
        check("r_cmd", bus.o_cmd, m_cmd);
        check("r_len", bus.o_len, m_len);
        if (idx < m_len) check("r_pay", bus.o_payload_byte, m_pl[idx]);
      end
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc(0, 8'h00, 0, 3'd0);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rx; logic [7:0] d; bit ack; logic [2:0] idx; bit pchk; logic [7:0] pexp;
    bit v; logic [7:0] cmd; logic [7:0] len; bit err; logic [1:0] code; bit ovr;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(bit rx, logic [7:0] d, bit ack, logic [2:0] idx, bit pchk,
                              logic [7:0] pexp, bit v, logic [7:0] cmd, logic [7:0] len,
                              bit err, logic [1:0] code, bit ovr);
    vec_t t;
    t.rx = rx; t.d = d; t.ack = ack; t.idx = idx; t.pchk = pchk; t.pexp = pexp;
    t.v = v; t.cmd = cmd; t.len = len; t.err = err; t.code = code; t.ovr = ovr;
    return t;
  endfunction

  typedef struct { int gap; logic [7:0] d; } item_t;
  item_t sq[$];

  task automatic push_item(input int gap, input logic [7:0] d);
    item_t it;
    it.gap = gap; it.d = d;
    sq.push_back(it);
  endtask

  initial begin
    bit         seen;
    logic [7:0] x, ln, b;
    int         nxt_gap, guard;

    bus.i_rx_done = 0; bus.i_rx_data = 0; bus.i_ack = 0; bus.i_rd_idx = 0;
    apply_reset(2);
    check("rst_valid", bus.o_frame_valid, 0);
    check("rst_cmd",   bus.o_cmd, 0);
    check("rst_len",   bus.o_len, 0);
    check("rst_err",   bus.o_frame_err, 0);
    check("rst_code",  bus.o_err_code, 0);
    check("rst_ovr",   bus.o_overrun, 0);

    //                rx d     ack idx pc pexp   v cmd    len    e c  o
    tv.push_back(mk(1, 8'hAA, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 8'h05, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 8'h02, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 8'h11, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 8'h22, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 8'h34, 0, 0, 1, 8'h11, 1, 8'h05, 8'h02, 0, 0, 0));
    tv.push_back(mk(0, 8'h00, 0, 1, 1, 8'h22, 1, 8'h05, 8'h02, 0, 0, 0));
    tv.push_back(mk(1, 8'h99, 0, 1, 1, 8'h22, 1, 8'h05, 8'h02, 0, 0, 1));
    tv.push_back(mk(1, 8'hAA, 1, 0, 1, 8'h11, 0, 8'h05, 8'h02, 0, 0, 1));
    tv.push_back(mk(1, 8'h07, 0, 0, 0, 8'h00, 0, 8'h05, 8'h02, 0, 0, 0));
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h05, 8'h02, 0, 0, 0));
    tv.push_back(mk(1, 8'hFF, 0, 0, 0, 8'h00, 0, 8'h05, 8'h02, 0, 0, 0));
    tv.push_back(mk(1, 8'hAA, 0, 0, 0, 8'h00, 0, 8'h05, 8'h02, 0, 0, 0));
    tv.push_back(mk(1, 8'h07, 0, 0, 0, 8'h00, 0, 8'h05, 8'h02, 0, 0, 0));
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h05, 8'h02, 0, 0, 0));
    tv.push_back(mk(1, 8'h07, 0, 0, 0, 8'h00, 1, 8'h07, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 8'hAA, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 8'h01, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 0, 0));
    tv.push_back(mk(1, 8'h09, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 1, 1, 0));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 1, 0));
    tv.push_back(mk(1, 8'hAA, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 1, 0));
    tv.push_back(mk(1, 8'h03, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 1, 0));
    tv.push_back(mk(1, 8'h01, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 1, 0));
    tv.push_back(mk(1, 8'h55, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 1, 0));
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 1, 2, 0));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 2, 0));
    tv.push_back(mk(1, 8'hAA, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 2, 0));
    tv.push_back(mk(1, 8'h0A, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 2, 0));
    tv.push_back(mk(1, 8'h01, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 2, 0));
    tv.push_back(mk(1, 8'h5A, 0, 0, 0, 8'h00, 0, 8'h07, 8'h00, 0, 2, 0));
    tv.push_back(mk(1, 8'h51, 0, 0, 1, 8'h5A, 1, 8'h0A, 8'h01, 0, 2, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h0A, 8'h01, 0, 2, 0));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h0A, 8'h01, 0, 2, 0));

    foreach (tv[i]) begin
      cyc(tv[i].rx, tv[i].d, tv[i].ack, tv[i].idx);
      check($sformatf("v%0d_valid", i), bus.o_frame_valid, tv[i].v);
      check($sformatf("v%0d_cmd", i),   bus.o_cmd,         tv[i].cmd);
      check($sformatf("v%0d_len", i),   bus.o_len,         tv[i].len);
      check($sformatf("v%0d_err", i),   bus.o_frame_err,   tv[i].err);
      check($sformatf("v%0d_code", i),  bus.o_err_code,    tv[i].code);
      check($sformatf("v%0d_ovr", i),   bus.o_overrun,     tv[i].ovr);
      if (tv[i].pchk) check($sformatf("v%0d_pay", i), bus.o_payload_byte, tv[i].pexp);
    end

    // Timeout: TO idle cycles after a mid-frame byte -> code 3 on the last one.
    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'h03, 0, 0);
    seen = 0;
    repeat (TO - 1) begin
      cyc(0, 8'h00, 0, 0);
      if (bus.o_frame_err) seen = 1;
    end
    check("to_early_err", seen, 0);
    cyc(0, 8'h00, 0, 0);
    check("to_err",  bus.o_frame_err, 1);
    check("to_code", bus.o_err_code, 3);

    // Byte on the terminal cycle wins; parsing carries on.
    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'h03, 0, 0);
    seen = 0;
    repeat (TO - 1) begin
      cyc(0, 8'h00, 0, 0);
      if (bus.o_frame_err) seen = 1;
    end
    cyc(1, 8'h00, 0, 0);
    if (bus.o_frame_err) seen = 1;
    check("term_no_err", seen, 0);
    cyc(1, 8'h03, 0, 0);
    check("term_valid", bus.o_frame_valid, 1);
    check("term_cmd",   bus.o_cmd, 8'h03);
    check("term_len",   bus.o_len, 8'h00);
    check("term_code",  bus.o_err_code, 3);
    cyc(0, 8'h00, 1, 0);

    // Reset in the middle of a payload: silent abort, then a clean frame.
    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'h04, 0, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    apply_reset(2);
    check("mr_valid", bus.o_frame_valid, 0);
    check("mr_err",   bus.o_frame_err, 0);
    check("mr_code",  bus.o_err_code, 0);
    cyc(1, 8'hAA, 0, 0);
    check("mr_err2", bus.o_frame_err, 0);
    cyc(1, 8'h04, 0, 0);
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h36, 0, 0);
    check("mr_fvalid", bus.o_frame_valid, 1);
    check("mr_cmd",    bus.o_cmd, 8'h04);
    check("mr_len",    bus.o_len, 8'h01);
    check("mr_pay",    bus.o_payload_byte, 8'h33);
    cyc(0, 8'h00, 1, 0);

    // Randomized streams vs. the reference model.
    cmp_model = 1;
    for (int f = 0; f < 80; f++) begin
      int r;
      r = $urandom_range(0, 9);
      sq.delete();
      nxt_gap = $urandom_range(0, 2);
      if (r == 0) begin
        push_item(nxt_gap, 8'($urandom_range(0, 255)));
      end else if (r == 1) begin
        push_item(nxt_gap, HDR);
        push_item($urandom_range(0, 2), 8'($urandom_range(0, 255)));
        push_item($urandom_range(0, 2), 8'($urandom_range(MAX_LEN + 1, 255)));
      end else if (r == 2) begin
        push_item(nxt_gap, HDR);
        push_item($urandom_range(0, 2), 8'($urandom_range(0, 255)));
        push_item($urandom_range(TO - 2, TO + 2), 8'($urandom_range(0, MAX_LEN)));
      end else begin
        ln = 8'($urandom_range(0, MAX_LEN));
        b  = 8'($urandom_range(0, 255));
        x  = b ^ ln;
        push_item(nxt_gap, HDR);
        push_item($urandom_range(0, 2), b);
        push_item($urandom_range(0, 2), ln);
        for (int k = 0; k < int'(ln); k++) begin
          b = 8'($urandom_range(0, 255));
          x = x ^ b;
          push_item($urandom_range(0, 2), b);
        end
        if ($urandom_range(0, 4) == 0) x = x ^ 8'($urandom_range(1, 255));
        push_item($urandom_range(0, 2), x);
      end
      foreach (sq[k]) begin
        guard = 0;
        while (m_held && guard < 100) begin
          cyc($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)),
              $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
          guard++;
        end
        if (m_held) cyc(0, 8'h00, 1, 0);
        repeat (sq[k].gap)
          cyc(0, 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
              3'($urandom_range(0, 7)));
        cyc(1, sq[k].d, 0, 3'($urandom_range(0, 7)));
      end
    end
    repeat (4) cyc(0, 8'h00, 0, 3'($urandom_range(0, 7)));
    cyc(0, 8'h00, 1, 0);
    cmp_model = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
